ckt_fault_core: RTL and testbench



---
 rtl/ckt_fault_core.sv | 85 ++++++++
 tb/tb_ckt_fault_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ckt_fault_core.sv
// Registered six-input stuck-at benchmark netlist; optional net forcing under `FAULT_INJECT_EN.
// Latency: 2 clocks from a valid vector to y/out_valid. Backpressure: none; one vector per clock.
module ckt_fault_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
`ifdef FAULT_INJECT_EN
  input  logic       fault_en,
  input  logic [3:0] fault_net,
  input  logic       fault_val,
`endif
  output logic       y,
  output logic       out_valid
);

  logic [5:0] in_q, in_d;
  logic       vld1_q, vld1_d;
  logic       y_q, y_d;
  logic       out_valid_q, out_valid_d;

  logic       in_a, in_b, in_c, in_d_bit, in_e, in_f;
  logic       w1, w2, w3, w4, w5, w6, w7, w8, yc;

  // fsel[k] marks net k (w1..w8, 9 = yc) as forced to fval.
  logic [9:1] fsel;
  logic       fval;

`ifdef FAULT_INJECT_EN
  always_comb begin
    fsel = '0;
    for (int i = 1; i <= 9; i++) begin
      if (fault_en && (fault_net == 4'(i))) fsel[i] = 1'b1;
    end
  end
  assign fval = fault_val;
`else
  assign fsel = '0;
  assign fval = 1'b0;
`endif

  assign {in_a, in_b, in_c, in_d_bit, in_e, in_f} = in_q;

  always_comb begin
    w1 = fsel[1] ? fval : (in_a & in_b);
    w2 = fsel[2] ? fval : (in_c | in_d_bit);
    w3 = fsel[3] ? fval : ~in_e;
    w4 = fsel[4] ? fval : ~(w2 & in_f);
    w5 = fsel[5] ? fval : (w1 ^ w3);
    w6 = fsel[6] ? fval : ~(w4 | in_d_bit);
    w7 = fsel[7] ? fval : (w5 | w6);
    w8 = fsel[8] ? fval : (in_b | in_f);
    yc = fsel[9] ? fval : (w7 & w8);
  end

  always_comb begin
    in_d        = in_valid ? {a, b, c, d, e, f} : in_q;
    vld1_d      = in_valid;
    y_d         = yc;
    out_valid_d = vld1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '0;
      vld1_q      <= 1'b0;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_q        <= in_d;
      vld1_q      <= vld1_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ckt_fault_core.sv
// Scoreboard bench for ckt_fault_core: driver queues hand-computed results, monitor pops on out_valid.
module tb_ckt_fault_core;

  logic clk, rst, in_valid;
  logic a, b, c, d, e, f;
  logic y, out_valid;
`ifdef FAULT_INJECT_EN
  logic       fault_en;
  logic [3:0] fault_net;
  logic       fault_val;
`endif

  ckt_fault_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
`ifdef FAULT_INJECT_EN
    .fault_en  (fault_en),
    .fault_net (fault_net),
    .fault_val (fault_val),
`endif
    .y         (y),
    .out_valid (out_valid)
  );

  typedef struct {
    logic exp;
    int   cyc;
    int   id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vid = 0;

  // y for vectors 1..15 ({a,b}=00): y = f & (~e | (c & ~d)).
  logic [15:1] seq_exp = 15'b001010100010001;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %b expected %b", nm, id, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s #%0d got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] v, input logic vld, input logic exp);
    @(posedge clk);
    #1;
    {a, b, c, d, e, f} = v;
    in_valid = vld;
    if (vld && !rst) begin
      sb.push_back('{exp, cyc, vid});
      vid++;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out out_valid=%b y=%b expected no output", out_valid, y);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        check("y", ex.id, y, ex.exp);
        check_int("latency", ex.id, cyc - ex.cyc, 2);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    {a, b, c, d, e, f} = 6'b111111;
`ifdef FAULT_INJECT_EN
    fault_en = 1'b0;
    fault_net = 4'd0;
    fault_val = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_y", 0, y, 1'b0);
    check("reset_out_valid", 0, out_valid, 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      check("post_reset_idle", i, out_valid, 1'b0);
    end

    drive(6'b000000, 1'b1, 1'b0);
    drive(6'b010000, 1'b1, 1'b1);
    drive(6'b110000, 1'b1, 1'b0);
    drive(6'b001101, 1'b1, 1'b1);
    drive(6'b001011, 1'b1, 1'b1);
    drive(6'b000011, 1'b1, 1'b0);
    repeat (3) drive(6'b000000, 1'b0, 1'b0);

    for (int i = 1; i <= 15; i++) drive(6'(i), 1'b1, seq_exp[i]);
    repeat (2) drive(6'b111111, 1'b0, 1'b0);
    drive(6'b000101, 1'b1, 1'b1);
    drive(6'b110000, 1'b0, 1'b0);
    drive(6'b001001, 1'b1, 1'b1);
    repeat (3) drive(6'b000000, 1'b0, 1'b0);

    drive(6'b010000, 1'b1, 1'b1);
    repeat (5) drive(6'b110000, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_y", 0, y, 1'b1);
    check("hold_out_valid", 0, out_valid, 1'b0);

`ifdef FAULT_INJECT_EN
    fault_en = 1'b1;
    fault_net = 4'd6;
    fault_val = 1'b0;
    drive(6'b001011, 1'b1, 1'b0);
    drive(6'b010000, 1'b1, 1'b1);
    repeat (2) drive(6'b000000, 1'b0, 1'b0);

    fault_net = 4'd9;
    fault_val = 1'b1;
    drive(6'b000000, 1'b1, 1'b1);
    repeat (2) drive(6'b000000, 1'b0, 1'b0);
    fault_en = 1'b0;
    repeat (2) drive(6'b000000, 1'b0, 1'b0);
    @(negedge clk);
    check("fault_removed_y", 0, y, 1'b0);

    drive(6'b000000, 1'b1, 1'b0);
    drive(6'b001011, 1'b1, 1'b1);
    repeat (2) drive(6'b000000, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check_int("scoreboard_drained", 0, sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
